// File: rtl/key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_sched_ctrl
// Purpose  : Sequences the masked AES key-expansion unit through one
//            encryption. It latches the encoded master key and offers each
//            round key over a valid/ready handshake. Each expanded key is
//            fed back as the next expansion input. A watchdog flags an
//            expansion unit that never answers.
// Revision : 1.0 - initial release
// ============================================================================
module key_sched_ctrl #(
  parameter int D       = 2,
  parameter int NR      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [3:0][3:0][0:7+D]   key_i,
  output logic                     busy,
  output logic                     ke_drdy_o,
  output logic                     ke_first_round,
  output logic [3:0][3:0][0:7+D]   ke_key_o,
  input  logic [3:0][3:0][0:7+D]   ke_key_i,
  input  logic                     ke_drdy_i,
  output logic                     rk_valid,
  input  logic                     rk_ready,
  output logic [3:0][3:0][0:7+D]   rk_data,
  output logic [3:0]               rk_round,
  output logic                     done,
  output logic                     err
);

  localparam int              WD_W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]      LAST_ROUND = 4'(NR);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_OFFER = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [3:0][3:0][0:7+D] cur_key;
  logic [3:0]             round;
  logic [WD_W-1:0]        wd_ctr;

  // State register; asynchronous reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a completed expansion beats a watchdog expiry in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_OFFER;
      S_OFFER: begin
        if (rk_ready) begin
          state_nxt = (round == LAST_ROUND) ? S_IDLE : S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ke_drdy_i) begin
          state_nxt = S_OFFER;
        end else if (wd_ctr == WD_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Key, round index, watchdog and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_key <= '0;
      round   <= '0;
      wd_ctr  <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_key <= key_i;
            round   <= '0;
            err     <= 1'b0;
          end
        end
        S_ISSUE: wd_ctr <= '0;
        S_WAIT: begin
          if (ke_drdy_i) begin
            cur_key <= ke_key_i;
            round   <= round + 4'd1;
          end else if (wd_ctr == WD_LAST) begin
            err <= 1'b1;
          end else begin
            wd_ctr <= wd_ctr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, except done which needs the accepting ready.
  always_comb begin
    busy           = (state != S_IDLE);
    rk_valid       = (state == S_OFFER);
    ke_drdy_o      = (state == S_ISSUE);
    ke_first_round = (state == S_LOAD) || ((state == S_ISSUE) && (round == 4'd0));
    done           = (state == S_OFFER) && rk_ready && (round == LAST_ROUND);
    ke_key_o       = cur_key;
    rk_data        = cur_key;
    rk_round       = round;
  end

endmodule
`default_nettype wire

// File: tb/tb_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_sched_ctrl
// Purpose  : Scoreboard bench for key_sched_ctrl with a behavioural
//            expansion-unit model and a round-key reference list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_sched_ctrl;

  localparam int D       = 2;
  localparam int NR      = 10;
  localparam int TIMEOUT = 64;
  localparam int BW      = 8 + D;
  localparam int KW      = 16 * BW;

  typedef logic [3:0][3:0][0:7+D] key_t;
  typedef struct {
    key_t       key;
    logic [3:0] rnd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  key_t       key_i;
  logic       busy;
  logic       ke_drdy_o;
  logic       ke_first_round;
  key_t       ke_key_o;
  key_t       ke_key_i;
  logic       ke_drdy_i;
  logic       rk_valid;
  logic       rk_ready;
  key_t       rk_data;
  logic [3:0] rk_round;
  logic       done;
  logic       err;

  key_sched_ctrl #(.D(D), .NR(NR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .key_i(key_i), .busy(busy),
    .ke_drdy_o(ke_drdy_o), .ke_first_round(ke_first_round), .ke_key_o(ke_key_o),
    .ke_key_i(ke_key_i), .ke_drdy_i(ke_drdy_i), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   e_fixed  = 5;     // >0 fixed latency, 0 random 1..8, <0 never answers
  bit   spur_drdy = 1'b0;
  bit   ready_rand = 1'b0;
  int   bp_req   = 0;
  bit   per_chk  = 1'b0;
  int   per_exp  = 0;

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Stand-in expansion function: any deterministic key/rcon mix serves.
  function automatic key_t expand(input key_t k, input logic [7:0] rc);
    logic [KW-1:0] v;
    v = k;
    v = {v[KW-BW-1:0], v[KW-1 -: BW]} ^ (v >> 3) ^ {{(KW-8){1'b0}}, rc};
    return v;
  endfunction

  function automatic key_t encode(input logic [127:0] raw);
    logic [KW-1:0] v;
    logic [7:0]    b;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      b = raw[127-8*i -: 8];
      v[KW-1-BW*i -: BW] = {b, {D{^b}}};
    end
    return v;
  endfunction

  function automatic key_t rand_key();
    return encode({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Reference: key r+1 is the expansion of key r with rcon starting at 0x80.
  task automatic push_schedule(input key_t mk, input int nkeys);
    key_t       k;
    logic [7:0] rc;
    k  = mk;
    rc = 8'h80;
    for (int r = 0; r <= NR; r++) begin
      if (r < nkeys) sb.push_back('{k, 4'(r)});
      k  = expand(k, rc);
      rc = {rc[0], rc[7:1]};
    end
  endtask

  // Expansion-unit model: answers E cycles after each start pulse.
  initial begin : exp_model
    int         cnt;
    key_t       res;
    logic [7:0] rcon;
    cnt = 0; res = '0; rcon = 8'h80;
    ke_drdy_i = 1'b0;
    ke_key_i  = '0;
    forever begin
      @(posedge clk); #1;
      ke_drdy_i = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            ke_drdy_i = 1'b1;
            ke_key_i  = res;
          end
        end else if (spur_drdy && $urandom_range(0, 3) == 0) begin
          ke_drdy_i = 1'b1;
          ke_key_i  = rand_key();
        end
        if (ke_first_round) rcon = 8'h80;
        if (ke_drdy_o) begin
          res  = expand(ke_key_o, rcon);
          rcon = {rcon[0], rcon[7:1]};
          if (e_fixed > 0) cnt = e_fixed;
          else if (e_fixed == 0) cnt = $urandom_range(1, 8);
        end
      end
    end
  end

  // Round-datapath ready: always, random, or a 20-cycle stall at round 3.
  initial begin : ready_drv
    int bp_cnt;
    int bp_done;
    bp_cnt = 0; bp_done = 0;
    rk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_cnt > 0) begin
        rk_ready = 1'b0;
        bp_cnt--;
      end else if (bp_req != bp_done && rk_valid && rk_round == 4'd3) begin
        bp_done++;
        bp_cnt   = 19;
        rk_ready = 1'b0;
      end else begin
        rk_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold behaviour.
  initial begin : monitor
    key_t       pdata;
    logic [3:0] pround;
    bit         stalled, pbusy, pdone;
    int         n_drdy, n_fr, last_hs;
    exp_t       e;
    stalled = 0; pbusy = 0; pdone = 0; n_drdy = 0; n_fr = 0; last_hs = 0;
    pdata = '0; pround = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        stalled = 0; pbusy = 0; pdone = 0;
        continue;
      end
      if (pdone) chk("idle_after_done", busy, 1'b0);
      pdone = done;
      if (busy && !pbusy) begin
        n_drdy = 0;
        n_fr   = 0;
      end
      pbusy = busy;
      if (ke_drdy_o) n_drdy++;
      if (ke_first_round) n_fr++;
      if (stalled) begin
        chk("stall_valid", rk_valid, 1'b1);
        chk("stall_data", rk_data, pdata);
        chk("stall_round", rk_round, pround);
        chk("stall_no_issue", ke_drdy_o, 1'b0);
      end
      stalled = rk_valid && !rk_ready;
      pdata   = rk_data;
      pround  = rk_round;
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: handshake at round %0d with no expected key", rk_round);
        end else begin
          e = sb.pop_front();
          chk("rk_data", rk_data, e.key);
          chk("rk_round", rk_round, e.rnd);
          chk("ke_key_o", ke_key_o, e.key);
          chk("done", done, (e.rnd == 4'(NR)));
          if (per_chk && e.rnd != 4'd0) chk("key_period", cyc - last_hs, per_exp);
          last_hs = cyc;
          if (e.rnd == 4'(NR)) begin
            chk("n_issue", n_drdy, NR);
            chk("n_first_round", n_fr, 2);
          end
        end
      end else if (done) begin
        checks++;
        failures++;
        $display("FAIL stray_done: got 1 expected 0 at round %0d", rk_round);
      end
    end
  end

  task automatic do_start(input key_t mk, input int nkeys);
    @(posedge clk); #2;
    key_i = mk;
    start = 1'b1;
    push_schedule(mk, nkeys);
    @(posedge clk); #2;
    start = 1'b0;
    key_i = rand_key();
    chk("load_first_round", ke_first_round, 1'b1);
    chk("load_no_valid", rk_valid, 1'b0);
    chk("load_err_clear", err, 1'b0);
    @(posedge clk); #2;
    chk("offer_latency", rk_valid, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input bit spur);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk); #2;
      if (!busy) break;
      start = spur && ($urandom_range(0, 4) == 0);
      key_i = rand_key();
      n++;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL idle_wait: busy still 1 after %0d cycles, expected 0", n);
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic wait_issue(input logic [3:0] rnd, input int budget);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk); #2;
      if (ke_drdy_o && rk_round == rnd) break;
      n++;
      if (n >= budget) begin
        checks++;
        failures++;
        $display("FAIL issue_wait: no ke_drdy_o at round %0d within %0d cycles", rnd, n);
        break;
      end
    end
  endtask

  initial begin : main
    key_t k;
    rst = 1'b1; start = 1'b0; key_i = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_ctrl", {busy, rk_valid, ke_drdy_o, ke_first_round, done, err, rk_round}, '0);
    chk("reset_rk_data", rk_data, '0);
    chk("reset_ke_key", ke_key_o, '0);
    rst = 1'b0;

    // FIPS-197 master key, ready tied high, E=5 -> a key every 7 cycles.
    e_fixed = 5; per_chk = 1'b1; per_exp = 7;
    do_start(encode(128'h2b7e151628aed2a6abf7158809cf4f3c), NR + 1);
    wait_idle(2000, 1'b0);
    per_chk = 1'b0;
    chk("fips_drained", sb.size(), 0);
    chk("fips_no_err", err, 1'b0);

    // Backpressure at round 3 with spurious done pulses and starts.
    e_fixed = 0; spur_drdy = 1'b1; bp_req++;
    do_start(rand_key(), NR + 1);
    wait_idle(2000, 1'b1);
    chk("bp_drained", sb.size(), 0);

    // Random ready and latency across several schedules.
    ready_rand = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_start(rand_key(), NR + 1);
      wait_idle(2000, 1'b1);
      chk("rand_drained", sb.size(), 0);
    end

    // Watchdog expiry: the expansion unit never answers.
    ready_rand = 1'b0; spur_drdy = 1'b0; e_fixed = -1;
    do_start(rand_key(), 1);
    wait_issue(4'd0, 50);
    repeat (TIMEOUT) @(posedge clk);
    #2;
    chk("wd_last_cycle_err", err, 1'b0);
    chk("wd_last_cycle_busy", busy, 1'b1);
    @(posedge clk); #2;
    chk("wd_err", err, 1'b1);
    chk("wd_idle", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("wd_err_sticky", err, 1'b1);

    // Done on the final watchdog cycle wins every round; a fresh start clears err.
    e_fixed = TIMEOUT;
    do_start(rand_key(), NR + 1);
    wait_idle(2000, 1'b0);
    chk("race_drained", sb.size(), 0);
    chk("race_no_err", err, 1'b0);

    // Asynchronous reset while waiting on the round-5 expansion.
    e_fixed = 40;
    do_start(rand_key(), NR + 1);
    wait_issue(4'd5, 1000);
    @(posedge clk); #3;
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_ctrl", {busy, rk_valid, ke_drdy_o, ke_first_round, done, err, rk_round}, '0);
    chk("rst_rk_data", rk_data, '0);
    chk("rst_ke_key", ke_key_o, '0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e_fixed = 3;
    k = rand_key();
    do_start(k, NR + 1);
    wait_idle(2000, 1'b0);
    chk("post_rst_drained", sb.size(), 0);

    repeat (3) @(posedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_guard
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
